// File: rtl/pad_cmd_scheduler.sv
// NES pad command scheduler: turns polled button samples into game commands.
// Press edges fire one-shot commands. Left/Right/Down add delayed auto-repeat.
// Pending commands are arbitrated by fixed priority onto one registered
// valid/ready port.
module pad_cmd_scheduler #(
    parameter int unsigned DAS_DELAY  = 10,
    parameter int unsigned ARR_PERIOD = 3,
    parameter int unsigned CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_valid,
    input  logic [7:0] btn_state,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    input  logic       cmd_ready,
    output logic       cmd_drop
);

    // Repeat channel index: 0 Left, 1 Right, 2 Down
    localparam int unsigned NumRep = 3;
    localparam logic [NumRep-1:0] LrMask = 3'b011;
    localparam logic [CNT_W-1:0] DasCnt = CNT_W'(DAS_DELAY);
    localparam logic [CNT_W-1:0] ArrCnt = CNT_W'(ARR_PERIOD);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

    logic [7:0]        prev_q;
    logic [7:0]        press;
    logic [NumRep-1:0] rep_held;
    logic [NumRep-1:0] rep_edge;
    logic [NumRep-1:0] rep_trig;
    logic              lr_conflict;

    rep_state_e        rep_q   [NumRep];
    rep_state_e        rep_d   [NumRep];
    logic [CNT_W-1:0]  cnt_q   [NumRep];
    logic [CNT_W-1:0]  cnt_d   [NumRep];
    logic [CNT_W-1:0]  cnt_inc [NumRep];

    // Pending bit j holds command code j+1
    logic [6:0] trig;
    logic [6:0] pend_q;
    logic [6:0] pend_d;
    logic [6:0] sel_mask;
    logic [6:0] clr_mask;
    logic [2:0] sel_cmd;
    logic       load;
    logic       drop_d;
    logic       cmd_valid_q;
    logic [2:0] cmd_q;
    logic       cmd_drop_q;

    // Press-edge detection and repeat-channel input mapping
    always_comb begin
        press       = btn_valid ? (btn_state & ~prev_q) : 8'h00;
        rep_held    = {btn_state[2], btn_state[0], btn_state[1]};
        rep_edge    = {press[2], press[0], press[1]};
        lr_conflict = btn_state[1] & btn_state[0];
        for (int r = 0; r < NumRep; r++) begin
            cnt_inc[r] = cnt_q[r] + CNT_W'(1);
        end
    end

    // Repeat FSM state and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NumRep; r++) begin
                rep_q[r] <= StIdle;
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NumRep; r++) begin
                rep_q[r] <= rep_d[r];
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Repeat FSM next state; only a poll sample moves the FSMs
    always_comb begin
        for (int r = 0; r < NumRep; r++) begin
            rep_d[r] = rep_q[r];
            cnt_d[r] = cnt_q[r];
            if (btn_valid) begin
                if (!rep_held[r] || (lr_conflict && LrMask[r])) begin
                    rep_d[r] = StIdle;
                    cnt_d[r] = '0;
                end else begin
                    unique case (rep_q[r])
                        StIdle: begin
                            if (rep_edge[r]) begin
                                rep_d[r] = StDelay;
                                cnt_d[r] = '0;
                            end
                        end
                        StDelay: begin
                            if (cnt_inc[r] == DasCnt) begin
                                rep_d[r] = StRepeat;
                                cnt_d[r] = '0;
                            end else begin
                                cnt_d[r] = cnt_inc[r];
                            end
                        end
                        StRepeat: begin
                            cnt_d[r] = (cnt_inc[r] == ArrCnt) ? '0 : cnt_inc[r];
                        end
                        default: begin
                            rep_d[r] = StIdle;
                            cnt_d[r] = '0;
                        end
                    endcase
                end
            end
        end
    end

    // Repeat FSM outputs: trigger strobes per channel
    always_comb begin
        rep_trig = '0;
        for (int r = 0; r < NumRep; r++) begin
            if (btn_valid) begin
                if (lr_conflict && LrMask[r]) begin
                    // Conflicting L+R: edges still count, repeat suppressed
                    rep_trig[r] = rep_edge[r];
                end else if (rep_held[r]) begin
                    unique case (rep_q[r])
                        StIdle:   rep_trig[r] = rep_edge[r];
                        StDelay:  rep_trig[r] = (cnt_inc[r] == DasCnt);
                        StRepeat: rep_trig[r] = (cnt_inc[r] == ArrCnt);
                        default:  rep_trig[r] = 1'b0;
                    endcase
                end
            end
        end
    end

    // Command triggers, priority select and pending update
    always_comb begin
        trig = {press[4], press[3], press[6], press[7], rep_trig[2], rep_trig[1], rep_trig[0]};

        sel_cmd  = 3'd0;
        sel_mask = 7'd0;
        if (pend_q[6]) begin
            sel_cmd  = 3'd7;
            sel_mask = 7'b1000000;
        end else if (pend_q[5]) begin
            sel_cmd  = 3'd6;
            sel_mask = 7'b0100000;
        end else if (pend_q[3]) begin
            sel_cmd  = 3'd4;
            sel_mask = 7'b0001000;
        end else if (pend_q[4]) begin
            sel_cmd  = 3'd5;
            sel_mask = 7'b0010000;
        end else if (pend_q[0]) begin
            sel_cmd  = 3'd1;
            sel_mask = 7'b0000001;
        end else if (pend_q[1]) begin
            sel_cmd  = 3'd2;
            sel_mask = 7'b0000010;
        end else if (pend_q[2]) begin
            sel_cmd  = 3'd3;
            sel_mask = 7'b0000100;
        end

        load     = (!cmd_valid_q || cmd_ready) && (|pend_q);
        clr_mask = load ? sel_mask : 7'd0;
        // A bit leaving for the output this cycle is not a coalesce target
        drop_d   = |(trig & pend_q & ~clr_mask);
        pend_d   = (pend_q & ~clr_mask) | trig;
    end

    // Sample history, pending bits and registered output port
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q      <= 8'h00;
            pend_q      <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= 3'd0;
            cmd_drop_q  <= 1'b0;
        end else begin
            if (btn_valid) begin
                prev_q <= btn_state;
            end
            pend_q     <= pend_d;
            cmd_drop_q <= drop_d;
            if (load) begin
                cmd_valid_q <= 1'b1;
                cmd_q       <= sel_cmd;
            end else if (cmd_ready) begin
                cmd_valid_q <= 1'b0;
                cmd_q       <= 3'd0;
            end
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign cmd_drop  = cmd_drop_q;

endmodule

// File: tb/tb_pad_cmd_scheduler.sv
// Scoreboard bench for pad_cmd_scheduler: stimulus pushes expected commands,
// a negedge monitor pops them on each handshake.
module tb_pad_cmd_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_valid;
    logic [7:0] btn_state;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;
    logic       cmd_drop;

    int n_checks = 0;
    int n_fail   = 0;
    int drop_seen = 0;

    logic [2:0] sb [$];
    logic       prev_stall = 1'b0;
    logic [2:0] prev_cmd   = 3'd0;

    pad_cmd_scheduler #(
        .DAS_DELAY (10),
        .ARR_PERIOD(3),
        .CNT_W     (6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_valid(btn_valid),
        .btn_state(btn_state),
        .cmd_valid(cmd_valid),
        .cmd      (cmd),
        .cmd_ready(cmd_ready),
        .cmd_drop (cmd_drop)
    );

    always #12.5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: handshake pops, stall stability, idle-zero, drop counting
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (cmd_drop) drop_seen++;
            if (prev_stall) begin
                check("stall_valid", int'(cmd_valid), 1);
                check("stall_cmd", int'(cmd), int'(prev_cmd));
            end
            if (!cmd_valid && cmd != 3'd0) check("idle_cmd_zero", int'(cmd), 0);
            if (cmd_valid && cmd_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_cmd", int'(cmd), 0);
                end else begin
                    check("cmd_order", int'(cmd), int'(sb.pop_front()));
                end
            end
            prev_stall = cmd_valid && !cmd_ready;
            prev_cmd   = cmd;
        end
    end

    task automatic poll(input logic [7:0] s, input int gap);
        @(posedge clk); #1;
        btn_valid = 1'b1;
        btn_state = s;
        @(posedge clk); #1;
        btn_valid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        while ((sb.size() != 0 || cmd_valid) && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        check(name, sb.size(), 0);
        if (sb.size() != 0) sb.delete();
    endtask

    initial begin
        reset     = 1'b1;
        btn_valid = 1'b0;
        btn_state = 8'h00;
        cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_valid", int'(cmd_valid), 0);
        check("reset_cmd", int'(cmd), 0);
        check("reset_drop", int'(cmd_drop), 0);

        // A press: two-cycle latency, single-cycle presentation
        sb.push_back(3'd4);
        poll(8'h80, 0);
        check("lat_k_valid", int'(cmd_valid), 0);
        @(posedge clk); #1;
        check("lat_k1_valid", int'(cmd_valid), 1);
        check("lat_k1_cmd", int'(cmd), 4);
        @(posedge clk); #1;
        check("one_cycle_valid", int'(cmd_valid), 0);
        poll(8'h80, 3);
        poll(8'h00, 3);
        wait_drain("drain_a");

        // Left held 20 polls: triggers at 0,10,13,16,19
        for (int p = 0; p < 20; p++) begin
            if (p == 0 || p == 10 || p == 13 || p == 16 || p == 19) sb.push_back(3'd1);
            poll(8'h02, 3);
        end
        poll(8'h00, 3);
        poll(8'h00, 3);
        wait_drain("drain_left_repeat");

        // Multi-press under backpressure: priority order, no bubbles
        cmd_ready = 1'b0;
        sb.push_back(3'd7);
        sb.push_back(3'd6);
        sb.push_back(3'd4);
        sb.push_back(3'd1);
        sb.push_back(3'd3);
        poll(8'h9E, 0);
        repeat (5) @(posedge clk);
        #1 cmd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("burst_valid", int'(cmd_valid), 1);
        end
        @(negedge clk);
        check("burst_end_valid", int'(cmd_valid), 0);
        poll(8'h00, 3);
        wait_drain("drain_burst");

        // Coalesce: second A press while ROT_CW pending -> one drop
        cmd_ready = 1'b0;
        sb.push_back(3'd5);
        sb.push_back(3'd4);
        poll(8'h40, 2);
        poll(8'hC0, 2);
        poll(8'h40, 2);
        poll(8'hC0, 4);
        check("drop_count", drop_seen, 1);
        #1 cmd_ready = 1'b1;
        poll(8'h00, 3);
        wait_drain("drain_coalesce");

        // Left+Right together: edges only, then Right release gives no Left repeat
        sb.push_back(3'd1);
        sb.push_back(3'd2);
        for (int p = 0; p < 15; p++) poll(8'h03, 2);
        for (int p = 0; p < 15; p++) poll(8'h02, 2);
        poll(8'h00, 2);
        sb.push_back(3'd1);
        poll(8'h02, 3);
        poll(8'h00, 3);
        wait_drain("drain_lr");

        // Reset while presenting with three pending
        cmd_ready = 1'b0;
        poll(8'hD8, 3);
        check("pre_reset_valid", int'(cmd_valid), 1);
        check("pre_reset_cmd", int'(cmd), 7);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("post_reset_valid", int'(cmd_valid), 0);
        check("post_reset_cmd", int'(cmd), 0);
        cmd_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1 check("quiet_after_reset", int'(cmd_valid), 0);

        // prev cleared by reset: held A yields a fresh edge
        sb.push_back(3'd4);
        poll(8'h80, 3);
        poll(8'h00, 3);
        wait_drain("drain_after_reset");
        check("total_drops", drop_seen, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time bound
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
